// File: rtl/capture_ctrl.sv
// DSO acquisition controller: adc_clk generation, triggered circular capture into the sample RAMs, readout mux.
// RAM controls are combinational from registered state; trigger is acted on 3 clk after the pin changes.
module capture_ctrl #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              adc_clk,
    input  logic              trig1,
    input  logic              trig2,
    input  logic              trig_src,
    input  logic              trig_edge,
    input  logic [ADDR_W-1:0] trig_pos,
    input  logic [3:0]        dec,
    input  logic              arm,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              en,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic              capturing,
    output logic              capture_done,
    output logic [ADDR_W-1:0] start_addr
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

    state_t              r_state;
    state_t              w_next;
    logic                r_adc_clk;
    logic [14:0]         r_slot_cnt;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W:0]     r_cnt;
    logic                r_src;
    logic                r_edge_pol;
    logic [ADDR_W-1:0]   r_tpos;
    logic [3:0]          r_dec;
    logic [2:0]          r_sync;
    logic                r_done;
    logic [ADDR_W-1:0]   r_start;

    logic                w_trig_sel;
    logic                w_edge;
    logic [14:0]         w_mask;
    logic                w_wslot;
    logic                w_cap;
    logic                w_wr;
    logic                w_arm_ok;
    logic [ADDR_W-1:0]   w_ptr_nxt;
    logic [ADDR_W:0]     w_cnt_nxt;
    logic [ADDR_W:0]     w_pre_target;

    assign w_trig_sel   = r_src ? trig2 : trig1;
    assign w_edge       = r_edge_pol ? (r_sync[1] & ~r_sync[2]) : (~r_sync[1] & r_sync[2]);
    assign w_mask       = ~(15'h7fff << r_dec);
    assign w_wslot      = r_adc_clk && ((r_slot_cnt & w_mask) == 15'd0);
    assign w_cap        = (r_state == ST_FILL) || (r_state == ST_ARMED) || (r_state == ST_POST);
    // POST with a zero post-count must drain to DONE without touching the RAM
    assign w_wr         = w_wslot && ((r_state == ST_FILL) || (r_state == ST_ARMED) ||
                                      ((r_state == ST_POST) && (r_tpos != '0)));
    assign w_arm_ok     = arm && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_ptr_nxt    = r_ptr + 1'b1;
    assign w_cnt_nxt    = r_cnt + 1'b1;
    assign w_pre_target = DEPTH_W - {1'b0, r_tpos};

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (arm) w_next = ST_FILL;
            ST_FILL:  if (w_wr && (w_cnt_nxt == w_pre_target)) w_next = ST_ARMED;
            ST_ARMED: if (w_edge) w_next = ST_POST;
            ST_POST: begin
                if (r_tpos == '0)
                    w_next = ST_DONE;
                else if (w_wr && (w_cnt_nxt == {1'b0, r_tpos}))
                    w_next = ST_DONE;
            end
            ST_DONE:  if (arm) w_next = ST_FILL;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_adc_clk  <= 1'b0;
            r_slot_cnt <= '0;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_src      <= 1'b0;
            r_edge_pol <= 1'b1;
            r_tpos     <= '0;
            r_dec      <= '0;
            r_sync     <= '0;
            r_done     <= 1'b0;
            r_start    <= '0;
        end else begin
            r_state   <= w_next;
            r_adc_clk <= ~r_adc_clk;
            r_sync    <= {r_sync[1:0], w_trig_sel};
            if (w_arm_ok) begin
                r_src      <= trig_src;
                r_edge_pol <= trig_edge;
                r_tpos     <= trig_pos;
                r_dec      <= dec;
                r_ptr      <= '0;
                r_cnt      <= '0;
                r_slot_cnt <= '0;
                r_done     <= 1'b0;
            end else begin
                if (w_cap && r_adc_clk)
                    r_slot_cnt <= r_slot_cnt + 1'b1;
                if (w_wr)
                    r_ptr <= w_ptr_nxt;
                // the write coincident with the accepted edge still belongs to the pre-trigger part
                if ((r_state == ST_ARMED) && w_edge)
                    r_cnt <= '0;
                else if (w_wr && ((r_state == ST_FILL) || (r_state == ST_POST)))
                    r_cnt <= w_cnt_nxt;
                if ((w_next == ST_DONE) && (r_state != ST_DONE)) begin
                    r_done  <= 1'b1;
                    r_start <= w_wr ? w_ptr_nxt : r_ptr;
                end
            end
        end
    end

    assign adc_clk      = r_adc_clk;
    assign capturing    = w_cap;
    assign en           = w_cap ? w_wr : rd_en;
    assign we           = w_wr;
    assign addr         = w_cap ? r_ptr : rd_addr;
    assign capture_done = r_done;
    assign start_addr   = r_start;

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl: write counting monitor plus hand-computed totals and start addresses.
module tb_capture_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       adc_clk;
    logic       trig1 = 1'b0, trig2 = 1'b0, trig_src = 1'b0, trig_edge = 1'b1;
    logic [8:0] trig_pos = '0;
    logic [3:0] dec = '0;
    logic       arm = 1'b0, rd_en = 1'b0;
    logic [8:0] rd_addr = '0;
    logic       en, we, capturing, capture_done;
    logic [8:0] addr, start_addr;

    int errors = 0, checks = 0;
    int wcnt = 0, base = 0, cyc = 0, last_cyc = 0, per = 0;
    int addr_err = 0, rd_leak = 0, a511 = -1, a512 = -1;

    capture_ctrl #(.DEPTH(512), .ADDR_W(9)) dut (
        .clk(clk), .rst_n(rst_n), .adc_clk(adc_clk),
        .trig1(trig1), .trig2(trig2), .trig_src(trig_src), .trig_edge(trig_edge),
        .trig_pos(trig_pos), .dec(dec), .arm(arm), .rd_en(rd_en), .rd_addr(rd_addr),
        .en(en), .we(we), .addr(addr), .capturing(capturing),
        .capture_done(capture_done), .start_addr(start_addr)
    );

    always #5 clk = ~clk;

    // Write monitor: expected address of every write is its index since arm, modulo 512
    always @(negedge clk) begin
        int rel;
        cyc++;
        if (capturing === 1'b1 && en === 1'b1 && we !== 1'b1) rd_leak++;
        if (we === 1'b1) begin
            rel = wcnt - base;
            if (int'(addr) != (rel % 512)) addr_err++;
            if (rel == 511) a511 = int'(addr);
            if (rel == 512) a512 = int'(addr);
            per = cyc - last_cyc;
            last_cyc = cyc;
            wcnt++;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_wr(input int n);
        int t = 0;
        while ((wcnt - base) < n && t < 20000) begin
            step();
            t++;
        end
        chk($sformatf("writes_reach_%0d", n), wcnt - base, n);
    endtask

    task automatic wait_done();
        int t = 0;
        while (capture_done !== 1'b1 && t < 20000) begin
            step();
            t++;
        end
        chk("done_seen", int'(capture_done), 1);
    endtask

    task automatic arm_go(input int tp, input int d, input logic src, input logic edg);
        step();
        trig_pos  = 9'(tp);
        dec       = 4'(d);
        trig_src  = src;
        trig_edge = edg;
        arm       = 1'b1;
        base      = wcnt;
        step();
        arm = 1'b0;
        chk("capturing_after_arm", int'(capturing), 1);
        chk("done_cleared_on_arm", int'(capture_done), 0);
    endtask

    initial begin
        #2;
        chk("rst_adc_clk", int'(adc_clk), 0);
        chk("rst_en", int'(en), 0);
        chk("rst_we", int'(we), 0);
        chk("rst_addr", int'(addr), 0);
        chk("rst_capturing", int'(capturing), 0);
        chk("rst_done", int'(capture_done), 0);
        chk("rst_start", int'(start_addr), 0);
        step();
        rst_n = 1'b1;
        repeat (3) step();
        rd_en = 1'b1; rd_addr = 9'd5;
        #1;
        chk("idle_rd_en", int'(en), 1);
        chk("idle_rd_we", int'(we), 0);
        chk("idle_rd_addr", int'(addr), 5);
        rd_addr = 9'd7;

        // dec=0, trig_pos=256, rising trig1 right after fill; stray arm in POST
        trig1 = 1'b0;
        arm_go(256, 0, 1'b0, 1'b1);
        wait_wr(10);
        chk("dec0_period", per, 2);
        wait_wr(255);
        step();
        trig1 = 1'b1;
        wait_wr(300);
        step(); arm = 1'b1; step(); arm = 1'b0;
        wait_done();
        chk("t1_total_writes", wcnt - base, 512);
        chk("t1_start_addr", int'(start_addr), 0);
        chk("t1_capturing_off", int'(capturing), 0);
        repeat (10) step();
        chk("t1_no_writes_in_done", wcnt - base, 512);
        chk("t1_done_rd_en", int'(en), 1);
        chk("t1_done_rd_addr", int'(addr), 7);

        // falling trig2, dec=2, trig_pos=10; inputs changed mid-capture must be ignored
        trig1 = 1'b0; trig2 = 1'b1;
        repeat (5) step();
        arm_go(10, 2, 1'b1, 1'b0);
        trig_pos = 9'd0; dec = 4'd0; trig_edge = 1'b1;
        wait_wr(2);
        chk("dec2_period", per, 8);
        wait_wr(502);
        trig2 = 1'b0;
        wait_done();
        chk("t3a_total_writes", wcnt - base, 512);
        chk("t3a_start_addr", int'(start_addr), 0);
        trig2 = 1'b1;
        repeat (5) step();
        arm_go(10, 2, 1'b1, 1'b0);
        wait_wr(522);
        trig2 = 1'b0;
        wait_done();
        chk("t3b_total_writes", wcnt - base, 532);
        chk("t3b_start_addr", int'(start_addr), 20);

        // trig_pos=0: DONE the cycle after POST, no POST write even on a slot
        arm_go(0, 0, 1'b0, 1'b1);
        wait_wr(512);
        step();
        trig1 = 1'b1;
        repeat (3) step();
        chk("t4_done_not_yet", int'(capture_done), 0);
        chk("t4_still_capturing", int'(capturing), 1);
        step();
        chk("t4_done_now", int'(capture_done), 1);
        chk("t4_total_writes", wcnt - base, 513);
        chk("t4_start_addr", int'(start_addr), 1);

        // wrap: trigger 100 writes after ARMED, trig_pos=50
        trig1 = 1'b0;
        arm_go(50, 0, 1'b0, 1'b1);
        wait_wr(561);
        step();
        trig1 = 1'b1;
        wait_done();
        chk("t5_total_writes", wcnt - base, 612);
        chk("t5_start_addr", int'(start_addr), 100);
        chk("t5_addr_511", a511, 511);
        chk("t5_addr_wrap_0", a512, 0);
        chk("addr_sequence_errors", addr_err, 0);
        chk("rd_en_leak_while_capturing", rd_leak, 0);

        // early trigger in FILL is ignored; then reset mid-capture
        trig1 = 1'b0;
        arm_go(100, 0, 1'b0, 1'b1);
        wait_wr(50);
        trig1 = 1'b1;
        wait_wr(600);
        chk("t6_no_done", int'(capture_done), 0);
        chk("t6_still_armed", int'(capturing), 1);
        rd_addr = 9'd5;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_adc_clk", int'(adc_clk), 0);
        chk("mid_rst_we", int'(we), 0);
        chk("mid_rst_capturing", int'(capturing), 0);
        chk("mid_rst_done", int'(capture_done), 0);
        chk("mid_rst_start", int'(start_addr), 0);
        chk("mid_rst_en", int'(en), 1);
        chk("mid_rst_addr", int'(addr), 5);
        rd_en = 1'b0;
        #1;
        chk("mid_rst_en_off", int'(en), 0);
        step();
        rst_n = 1'b1;
        base = wcnt;
        repeat (10) step();
        chk("post_rst_idle", int'(capturing), 0);
        chk("post_rst_no_writes", wcnt - base, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
